layer_compositor: RTL and testbench

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/layer_compositor.sv | 98 +++++++++
 tb/tb_layer_compositor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Two-stage priority compositor for CARS car layers over a background, with an
// optional per-frame player collision tracker enabled by LAYER_COLLISION_EN.
module layer_compositor #(
  parameter int CARS    = 6,
  parameter int COLOR_W = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_on,
  input  logic                      frame_tick,
  input  logic [CARS-1:0]           on_cars,
  input  logic [3*COLOR_W*CARS-1:0] cars_rgb,
  input  logic [3*COLOR_W-1:0]      bg_rgb,
  output logic [3*COLOR_W-1:0]      rgb,
  output logic [CARS-1:0]           hit_cars,
  output logic                      crash
);

  localparam int PW = 3 * COLOR_W;

  logic [CARS-1:0] win_mask;
  logic [PW-1:0]   win_rgb;

  // Isolating the lowest set bit gives the highest-priority (lowest-index) car.
  assign win_mask = on_cars & (-on_cars);

  always_comb begin
    win_rgb = '0;
    for (int i = 0; i < CARS; i++) begin
      win_rgb = win_rgb | ({PW{win_mask[i]}} & cars_rgb[i*PW +: PW]);
    end
  end

  logic [CARS-1:0] win_mask_q;
  logic [PW-1:0]   win_rgb_q;
  logic [PW-1:0]   bg_q;
  logic            video_on_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_mask_q <= '0;
      win_rgb_q  <= '0;
      bg_q       <= '0;
      video_on_q <= 1'b0;
      rgb        <= '0;
    end else begin
      win_mask_q <= win_mask;
      win_rgb_q  <= win_rgb;
      bg_q       <= bg_rgb;
      video_on_q <= video_on;
      if (!video_on_q) begin
        rgb <= '0;
      end else if (|win_mask_q) begin
        rgb <= win_rgb_q;
      end else begin
        rgb <= bg_q;
      end
    end
  end

`ifdef LAYER_COLLISION_EN
  logic [CARS-1:0] hit_now;
  logic [CARS-1:0] acc;
  logic [CARS-1:0] frame_hits;

  always_comb begin
    hit_now = '0;
    for (int i = 1; i < CARS; i++) begin
      hit_now[i] = video_on & on_cars[0] & on_cars[i];
    end
  end

  // The tick pixel's own hits belong to the frame it closes.
  assign frame_hits = acc | hit_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      hit_cars <= '0;
      crash    <= 1'b0;
    end else if (frame_tick) begin
      acc      <= '0;
      hit_cars <= frame_hits;
      crash    <= |frame_hits;
    end else begin
      acc      <= frame_hits;
      crash    <= 1'b0;
    end
  end
`else
  logic collision_unused;

  assign collision_unused = frame_tick;
  assign hit_cars         = '0;
  assign crash            = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized bench for layer_compositor against a per-pixel / per-frame
// reference model; collision expectations follow LAYER_COLLISION_EN.
module tb_layer_compositor;

  localparam int CARS = 6;
  localparam int CW   = 1;
  localparam int PW   = 3 * CW;
  localparam int ALLW = PW * CARS;
`ifdef LAYER_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            video_on = 1'b0;
  logic            frame_tick = 1'b0;
  logic [CARS-1:0] on_cars = '0;
  logic [ALLW-1:0] cars_rgb = '0;
  logic [PW-1:0]   bg_rgb = '0;
  logic [PW-1:0]   rgb;
  logic [CARS-1:0] hit_cars;
  logic            crash;

  int tests = 0;
  int failed = 0;

  // Reference model state
  logic [PW-1:0]   exp_q[$];
  logic [PW-1:0]   exp_rgb;
  logic [CARS-1:0] exp_hit, pend_hit, frame_acc;
  logic            exp_crash, pend_crash;

  layer_compositor #(.CARS(CARS), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
    .on_cars(on_cars), .cars_rgb(cars_rgb), .bg_rgb(bg_rgb),
    .rgb(rgb), .hit_cars(hit_cars), .crash(crash)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] model_pixel(input logic vid, input logic [CARS-1:0] on,
                                                input logic [ALLW-1:0] cols, input logic [PW-1:0] bg);
    if (!vid) return '0;
    for (int i = 0; i < CARS; i++) if (on[i]) return cols[i*PW +: PW];
    return bg;
  endfunction

  function automatic logic [CARS-1:0] model_hits(input logic vid, input logic [CARS-1:0] on);
    logic [CARS-1:0] h = '0;
    if (COLL_EN && vid && on[0])
      for (int i = 1; i < CARS; i++) h[i] = on[i];
    return h;
  endfunction

  // Applies one pixel just after a rising edge; exp_* then describe the outputs
  // seen at the following falling edge.
  task automatic drive_pixel(input logic vid, input logic tick, input logic [CARS-1:0] on,
                             input logic [ALLW-1:0] cols, input logic [PW-1:0] bg);
    logic [CARS-1:0] h;
    @(posedge clk); #1;
    video_on = vid; frame_tick = tick; on_cars = on; cars_rgb = cols; bg_rgb = bg;
    exp_hit   = pend_hit;
    exp_crash = pend_crash;
    exp_q.push_back(model_pixel(vid, on, cols, bg));
    exp_rgb = exp_q.pop_front();
    h = model_hits(vid, on);
    if (tick) begin
      pend_hit   = frame_acc | h;
      pend_crash = |(frame_acc | h);
      frame_acc  = '0;
    end else begin
      frame_acc  = frame_acc | h;
      pend_crash = 1'b0;
    end
  endtask

  task automatic reset_on();
    @(posedge clk); #1;
    reset = 1'b1;
    video_on = 1'b0; frame_tick = 1'b0; on_cars = '0; cars_rgb = '0; bg_rgb = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    pend_hit = '0; pend_crash = 1'b0; frame_acc = '0;
  endtask

  task automatic reset_off();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [ALLW-1:0] rand_cols();
    return ALLW'($urandom);
  endfunction

  task automatic test_reset();
    reset_on();
    #1;
    tests++; if (rgb !== '0) begin failed++; $display("FAIL reset_rgb got %b exp %b", rgb, 3'b000); end
    tests++; if (hit_cars !== '0) begin failed++; $display("FAIL reset_hit got %b exp %b", hit_cars, 6'b0); end
    tests++; if (crash !== 1'b0) begin failed++; $display("FAIL reset_crash got %b exp 0", crash); end
    reset_off();
    for (int n = 0; n < 4; n++) begin
      drive_pixel(1'b1, 1'b0, '0, rand_cols(), 3'b101);
      @(negedge clk);
      tests++; if (rgb !== exp_rgb) begin failed++; $display("FAIL post_reset_rgb got %b exp %b", rgb, exp_rgb); end
    end
  endtask

  task automatic test_priority();
    logic [ALLW-1:0] cols;
    cols = rand_cols();
    cols[2*PW +: PW] = 3'b100; cols[3*PW +: PW] = 3'b001; cols[5*PW +: PW] = 3'b111;
    drive_pixel(1'b1, 1'b0, 6'b000000, cols, 3'b010);
    @(negedge clk);
    drive_pixel(1'b1, 1'b0, 6'b101100, cols, 3'b011);
    @(negedge clk);
    drive_pixel(1'b1, 1'b0, 6'b000000, cols, 3'b000);
    @(negedge clk);
    tests++; if (rgb !== 3'b010) begin failed++; $display("FAIL prio_bg got %b exp %b", rgb, 3'b010); end
    drive_pixel(1'b1, 1'b0, 6'b000000, cols, 3'b000);
    @(negedge clk);
    tests++; if (rgb !== 3'b100) begin failed++; $display("FAIL prio_car2 got %b exp %b", rgb, 3'b100); end
    for (int n = 0; n < 60; n++) begin
      drive_pixel(1'b1, 1'b0, CARS'($urandom) & {CARS{$urandom_range(0, 3) != 0}}, rand_cols(), PW'($urandom));
      @(negedge clk);
      tests++; if (rgb !== exp_rgb) begin failed++; $display("FAIL prio_rand got %b exp %b", rgb, exp_rgb); end
    end
  endtask

  task automatic test_video_off();
    logic [ALLW-1:0] cols;
    cols = rand_cols();
    cols[0 +: PW] = 3'b110;
    drive_pixel(1'b1, 1'b1, '0, cols, 3'b000);
    drive_pixel(1'b0, 1'b0, 6'b000001, cols, 3'b111);
    drive_pixel(1'b0, 1'b0, 6'b111111, cols, 3'b111);
    drive_pixel(1'b1, 1'b1, 6'b000000, cols, 3'b001);
    @(negedge clk);
    tests++; if (rgb !== 3'b000) begin failed++; $display("FAIL vid_off_rgb got %b exp %b", rgb, 3'b000); end
    drive_pixel(1'b1, 1'b0, 6'b000000, cols, 3'b001);
    @(negedge clk);
    tests++; if (rgb !== exp_rgb) begin failed++; $display("FAIL vid_off_rgb2 got %b exp %b", rgb, exp_rgb); end
    tests++; if (hit_cars !== '0) begin failed++; $display("FAIL vid_off_hit got %b exp %b", hit_cars, 6'b0); end
    tests++; if (crash !== exp_crash) begin failed++; $display("FAIL vid_off_crash got %b exp %b", crash, exp_crash); end
  endtask

  task automatic test_collision_frame();
    logic [CARS-1:0] on;
    drive_pixel(1'b1, 1'b1, '0, rand_cols(), '0);
    for (int n = 0; n < 10; n++) begin
      on = (n >= 3 && n <= 5) ? 6'b010001 : 6'b000100;
      drive_pixel(1'b1, 1'b0, on, rand_cols(), PW'($urandom));
      @(negedge clk);
      tests++; if (crash !== exp_crash) begin failed++; $display("FAIL coll_crash got %b exp %b", crash, exp_crash); end
    end
    drive_pixel(1'b1, 1'b1, '0, rand_cols(), '0);
    drive_pixel(1'b1, 1'b0, '0, rand_cols(), '0);
    @(negedge clk);
    tests++; if (hit_cars !== (COLL_EN ? 6'b010000 : 6'b000000)) begin
      failed++; $display("FAIL coll_hit got %b exp %b", hit_cars, COLL_EN ? 6'b010000 : 6'b000000); end
    tests++; if (crash !== COLL_EN) begin failed++; $display("FAIL coll_pulse got %b exp %b", crash, COLL_EN); end
    for (int n = 0; n < 6; n++) begin
      drive_pixel(1'b1, n == 4, 6'b000010, rand_cols(), '0);
      @(negedge clk);
      tests++; if (hit_cars !== exp_hit) begin failed++; $display("FAIL coll_hold got %b exp %b", hit_cars, exp_hit); end
      tests++; if (crash !== exp_crash) begin failed++; $display("FAIL coll_one got %b exp %b", crash, exp_crash); end
    end
    tests++; if (hit_cars !== '0) begin failed++; $display("FAIL coll_empty got %b exp %b", hit_cars, 6'b0); end
  endtask

  task automatic test_tick_pixel();
    drive_pixel(1'b1, 1'b1, '0, rand_cols(), '0);
    for (int n = 0; n < 4; n++) drive_pixel(1'b1, 1'b0, 6'b000010, rand_cols(), '0);
    drive_pixel(1'b1, 1'b1, 6'b000011, rand_cols(), '0);
    drive_pixel(1'b1, 1'b0, 6'b000011, rand_cols(), '0);
    @(negedge clk);
    tests++; if (hit_cars !== (COLL_EN ? 6'b000010 : 6'b000000)) begin
      failed++; $display("FAIL tick_hit got %b exp %b", hit_cars, COLL_EN ? 6'b000010 : 6'b000000); end
    tests++; if (crash !== COLL_EN) begin failed++; $display("FAIL tick_crash got %b exp %b", crash, COLL_EN); end
    for (int n = 0; n < 4; n++) begin
      drive_pixel(1'b1, n == 2, '0, rand_cols(), '0);
      @(negedge clk);
      tests++; if (hit_cars !== exp_hit) begin failed++; $display("FAIL tick_next got %b exp %b", hit_cars, exp_hit); end
      tests++; if (crash !== exp_crash) begin failed++; $display("FAIL tick_next_crash got %b exp %b", crash, exp_crash); end
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_pixel(1'b1, 1'b1, '0, rand_cols(), '0);
    for (int n = 0; n < 3; n++) drive_pixel(1'b1, 1'b0, 6'b001001, rand_cols(), '0);
    reset_on();
    #1;
    tests++; if (rgb !== '0) begin failed++; $display("FAIL mid_rst_rgb got %b exp %b", rgb, 3'b000); end
    reset_off();
    for (int n = 0; n < 7; n++) begin
      drive_pixel(1'b1, n == 4, 6'b001000, rand_cols(), PW'($urandom));
      @(negedge clk);
      tests++; if (rgb !== exp_rgb) begin failed++; $display("FAIL mid_rst_pix got %b exp %b", rgb, exp_rgb); end
      tests++; if (hit_cars !== '0) begin failed++; $display("FAIL mid_rst_hit got %b exp %b", hit_cars, 6'b0); end
      tests++; if (crash !== 1'b0) begin failed++; $display("FAIL mid_rst_crash got %b exp 0", crash); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      drive_pixel(1'b1, n >= 2, ($urandom_range(0, 2) == 0) ? (CARS'($urandom) | 6'b000001) : '0,
                  rand_cols(), PW'($urandom));
      @(negedge clk);
      tests++; if (hit_cars !== exp_hit) begin failed++; $display("FAIL b2b_hit got %b exp %b", hit_cars, exp_hit); end
      tests++; if (crash !== exp_crash) begin failed++; $display("FAIL b2b_crash got %b exp %b", crash, exp_crash); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_pixel($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                  CARS'($urandom) & CARS'($urandom), rand_cols(), PW'($urandom));
      @(negedge clk);
      tests++; if (rgb !== exp_rgb) begin failed++; $display("FAIL rand_rgb got %b exp %b", rgb, exp_rgb); end
      tests++; if (hit_cars !== exp_hit) begin failed++; $display("FAIL rand_hit got %b exp %b", hit_cars, exp_hit); end
      tests++; if (crash !== exp_crash) begin failed++; $display("FAIL rand_crash got %b exp %b", crash, exp_crash); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_video_off();
    test_collision_frame();
    test_tick_pixel();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
